// File: rtl/cnu_pkg.sv
// Shared definitions for the check-node expansion stage.
// Optional build macro: OFFSET_EN (offset min-sum magnitude correction).
package cnu_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 8;
  localparam int D_DEF  = 5;
  localparam int REC_W  = 2*DATA_W + IDX_W + D_DEF + 1;

  function automatic logic parity(input logic [31:0] s);
    return ^s;
  endfunction

  function automatic logic [31:0] sat_sub(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/cnu_rec_fifo.sv
// Small synchronous record FIFO with combinational head.
// Optional build macro: OFFSET_EN (not used in this file).
module cnu_rec_fifo
  import cnu_pkg::*;
#(
  parameter int W     = REC_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cnu_expand.sv
// Check-node output stage: expands min/min2/idx records into D messages.
// Optional build macro: OFFSET_EN (saturating offset on output magnitude).
module cnu_expand
  import cnu_pkg::*;
#(
  parameter int data_w = DATA_W,
  parameter int idx_w  = IDX_W,
  parameter int D      = D_DEF,
  parameter int DEPTH  = 2,
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] min,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  min_idx,
  input  logic [D-1:0]      sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_last
);

  localparam int RW = 2*data_w + idx_w + D + 1;

  logic [RW-1:0]     din;
  logic [RW-1:0]     head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              last;
  logic [idx_w-1:0]  k;
  logic [data_w-1:0] h_min;
  logic [data_w-1:0] h_min2;
  logic [idx_w-1:0]  h_idx;
  logic [D-1:0]      h_sign;
  logic              h_par;
  logic [D-1:0]      sh;
  logic [data_w-1:0] sel;
  logic [data_w-1:0] mag;
  logic              sgn;

  assign din = {min, min2, min_idx, sign,
                parity({{(32-D){1'b0}}, sign})};
  assign {h_min, h_min2, h_idx, h_sign, h_par} = head;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign last      = (k == idx_w'(D-1));
  assign pop       = out_valid && out_ready && last;

  cnu_rec_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // edge counter steps on each accepted message, wraps at D-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (out_valid && out_ready) begin
      k <= last ? '0 : k + 1'b1;
    end
  end

  // message regeneration from head record and edge counter
  always_comb begin
    sh       = '0;
    sel      = '0;
    mag      = '0;
    sgn      = 1'b0;
    out      = '0;
    out_idx  = k;
    out_last = 1'b0;
    sh  = h_sign >> k;
    sel = (k == h_idx) ? h_min2 : h_min;
`ifdef OFFSET_EN
    mag = data_w'(sat_sub(32'(sel), 32'(OFFSET)));
    sgn = (mag != '0) && (h_par ^ sh[0]);
`else
    mag = sel;
    sgn = h_par ^ sh[0];
`endif
    if (!empty) begin
      out      = {sgn, mag};
      out_last = last;
    end
  end

endmodule
